id_fwd_stage: RTL

Pipelined instruction-decode stage for the MIPS core, sitting between the IF/ID latch and the EX stage. It decodes a subset of MIPS32 logic, shift and arithmetic instructions plus LW. It resolves operands with EX/MEM forwarding and detects load-use hazards, stalling upstream when one is found. It drives a registered ID/EX output with a valid/ready handshake, so EX sees a clean one-cycle-latency interface.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/id_operand_mux.sv | 48 ++++
 rtl/id_fwd_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU operation and
// result-class enums used between ID and EX.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    typedef enum logic [7:0] {
        AluNop  = 8'h00,
        AluOr   = 8'h25,
        AluAnd  = 8'h24,
        AluXor  = 8'h26,
        AluNor  = 8'h27,
        AluAddu = 8'h21,
        AluSubu = 8'h23,
        AluSll  = 8'h7c,
        AluSrl  = 8'h02,
        AluLui  = 8'h5c,
        AluLw   = 8'he3
    } aluop_t;

    typedef enum logic [2:0] {
        SelNop   = 3'd0,
        SelLogic = 3'd1,
        SelShift = 3'd2,
        SelArith = 3'd4,
        SelLoad  = 3'd7
    } alusel_t;

endpackage

// File: rtl/id_operand_mux.sv
// Resolves one source operand: immediate, $0, EX bypass, MEM bypass or regfile,
// and reports which in-flight writers match the source register.
module id_operand_mux
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic [4:0]        addr_i,
    input  logic              read_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] operand_o,
    output logic              ex_hit_o,
    output logic              ex_load_hit_o,
    output logic              mem_hit_o
);

    logic used;

    // $0 is hardwired, so it never matches a pending write.
    assign used          = read_i && (addr_i != NOP_REG_ADDR);
    assign ex_hit_o      = used && ex_wreg_i && (ex_wd_i == addr_i);
    assign ex_load_hit_o = ex_hit_o && ex_is_load_i;
    assign mem_hit_o     = used && mem_wreg_i && (mem_wd_i == addr_i);

    always_comb begin
        if (!read_i) begin
            operand_o = imm_i;
        end else if (!used) begin
            operand_o = '0;
        end else if (FWD_EN && ex_hit_o && !ex_is_load_i) begin
            operand_o = ex_wdata_i;
        end else if (FWD_EN && mem_hit_o) begin
            operand_o = mem_wdata_i;
        end else begin
            operand_o = rf_data_i;
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// MIPS decode stage: decodes logic/shift/arith/LW, forwards from EX/MEM,
// stalls on load-use and presents a registered valid/ready output to EX.
module id_fwd_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    output logic [4:0]        reg1_addr_o,
    output logic [4:0]        reg2_addr_o,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output aluop_t            aluop_o,
    output alusel_t           alusel_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic              is_load_o,
    output logic [31:0]       pc_o,
    output logic              instvalid_o
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    aluop_t            aluop_d;
    alusel_t           alusel_d;
    logic              re1, re2, wreg_d, is_load_d, instvalid_d;
    logic [4:0]        wd_d;
    logic [DATA_W-1:0] imm;

    always_comb begin
        aluop_d     = AluNop;
        alusel_d    = SelNop;
        re1         = 1'b0;
        re2         = 1'b0;
        wreg_d      = 1'b0;
        wd_d        = NOP_REG_ADDR;
        imm         = '0;
        is_load_d   = 1'b0;
        instvalid_d = 1'b0;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                aluop_d     = (op == OP_ORI) ? AluOr : (op == OP_ANDI) ? AluAnd : AluXor;
                alusel_d    = SelLogic;
                re1         = 1'b1;
                imm         = DATA_W'(imm16);
                wreg_d      = 1'b1;
                wd_d        = rt;
                instvalid_d = 1'b1;
            end
            OP_LUI: begin
                aluop_d     = AluLui;
                alusel_d    = SelLogic;
                imm         = DATA_W'({imm16, 16'h0000});
                wreg_d      = 1'b1;
                wd_d        = rt;
                instvalid_d = 1'b1;
            end
            OP_LW: begin
                aluop_d     = AluLw;
                alusel_d    = SelLoad;
                re1         = 1'b1;
                imm         = {{(DATA_W-16){imm16[15]}}, imm16};
                wreg_d      = 1'b1;
                wd_d        = rt;
                is_load_d   = 1'b1;
                instvalid_d = 1'b1;
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_ADDU, FN_SUBU: begin
                        re1         = 1'b1;
                        re2         = 1'b1;
                        wreg_d      = 1'b1;
                        wd_d        = rd;
                        instvalid_d = 1'b1;
                        case (funct)
                            FN_AND:  begin aluop_d = AluAnd;  alusel_d = SelLogic; end
                            FN_OR:   begin aluop_d = AluOr;   alusel_d = SelLogic; end
                            FN_XOR:  begin aluop_d = AluXor;  alusel_d = SelLogic; end
                            FN_NOR:  begin aluop_d = AluNor;  alusel_d = SelLogic; end
                            FN_ADDU: begin aluop_d = AluAddu; alusel_d = SelArith; end
                            default: begin aluop_d = AluSubu; alusel_d = SelArith; end
                        endcase
                    end
                    FN_SLL, FN_SRL: begin
                        aluop_d     = (funct == FN_SLL) ? AluSll : AluSrl;
                        alusel_d    = SelShift;
                        re2         = 1'b1;
                        imm         = DATA_W'(sa);
                        wreg_d      = 1'b1;
                        wd_d        = rd;
                        instvalid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign reg1_addr_o = rst ? NOP_REG_ADDR : rs;
    assign reg2_addr_o = rst ? NOP_REG_ADDR : rt;
    assign reg1_read_o = !rst && re1;
    assign reg2_read_o = !rst && re2;

    logic [DATA_W-1:0] op1, op2;
    logic              ex_hit1, ex_hit2, ld_hit1, ld_hit2, mem_hit1, mem_hit2;

    id_operand_mux #(.DATA_W(DATA_W), .FWD_EN(FWD_EN)) u_mux1 (
        .addr_i       (reg1_addr_o),
        .read_i       (reg1_read_o),
        .rf_data_i    (reg1_data_i),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_is_load_i (ex_is_load_i),
        .mem_wreg_i   (mem_wreg_i),
        .mem_wd_i     (mem_wd_i),
        .mem_wdata_i  (mem_wdata_i),
        .imm_i        (imm),
        .operand_o    (op1),
        .ex_hit_o     (ex_hit1),
        .ex_load_hit_o(ld_hit1),
        .mem_hit_o    (mem_hit1)
    );

    id_operand_mux #(.DATA_W(DATA_W), .FWD_EN(FWD_EN)) u_mux2 (
        .addr_i       (reg2_addr_o),
        .read_i       (reg2_read_o),
        .rf_data_i    (reg2_data_i),
        .ex_wreg_i    (ex_wreg_i),
        .ex_wd_i      (ex_wd_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_is_load_i (ex_is_load_i),
        .mem_wreg_i   (mem_wreg_i),
        .mem_wd_i     (mem_wd_i),
        .mem_wdata_i  (mem_wdata_i),
        .imm_i        (imm),
        .operand_o    (op2),
        .ex_hit_o     (ex_hit2),
        .ex_load_hit_o(ld_hit2),
        .mem_hit_o    (mem_hit2)
    );

    logic stall, advance, load, out_valid_q, out_valid_d;

    // Without forwarding every RAW hazard on EX or MEM must wait in ID.
    assign stall = in_valid &&
                   (ld_hit1 || ld_hit2 ||
                    (!FWD_EN && (ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2)));
    assign advance = !out_valid_q || out_ready;

    always_comb begin
        in_ready    = 1'b0;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        if (rst) begin
            out_valid_d = 1'b0;
        end else if (flush_i) begin
            out_valid_d = 1'b0;
            in_ready    = 1'b1;
        end else if (advance) begin
            if (stall) begin
                out_valid_d = 1'b0;
            end else begin
                in_ready    = 1'b1;
                out_valid_d = in_valid;
                load        = in_valid;
            end
        end
    end

    aluop_t            aluop_q;
    alusel_t           alusel_q;
    logic [DATA_W-1:0] reg1_q, reg2_q;
    logic [4:0]        wd_q;
    logic              wreg_q, is_load_q, instvalid_q;
    logic [31:0]       pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            aluop_q     <= AluNop;
            alusel_q    <= SelNop;
            reg1_q      <= '0;
            reg2_q      <= '0;
            wd_q        <= NOP_REG_ADDR;
            wreg_q      <= 1'b0;
            is_load_q   <= 1'b0;
            pc_q        <= '0;
            instvalid_q <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            if (load) begin
                aluop_q     <= aluop_d;
                alusel_q    <= alusel_d;
                reg1_q      <= op1;
                reg2_q      <= op2;
                wd_q        <= wd_d;
                wreg_q      <= wreg_d;
                is_load_q   <= is_load_d;
                pc_q        <= pc_i;
                instvalid_q <= instvalid_d;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign aluop_o     = aluop_q;
    assign alusel_o    = alusel_q;
    assign reg1_o      = reg1_q;
    assign reg2_o      = reg2_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign is_load_o   = is_load_q;
    assign pc_o        = pc_q;
    assign instvalid_o = instvalid_q;

endmodule
